// File: rtl/dsp48e1_pkg.sv
// Shared definitions for the DSP48E1 MAC sequencer: OPMODE/ALUMODE
// encodings, the sequencer state enum and the in-flight tag record.
package dsp48e1_pkg;

  // OPMODE: Z=0, Y=M, X=M  -> P = A*B (first term of a dot product)
  localparam logic [6:0] OPM_MUL = 7'h05;
  // OPMODE: Z=P, Y=M, X=M  -> P = P + A*B (subsequent terms)
  localparam logic [6:0] OPM_MAC = 7'h25;

  // ALUMODE: Z + X + Y + CIN
  localparam logic [3:0] ALUMODE_ADD = 4'h0;
  // CARRYINSEL: CARRYIN pin (tied low by the parent)
  localparam logic [2:0] CARRYINSEL_PIN = 3'b000;
  // INMODE: A2/B2 registers, no pre-adder
  localparam logic [4:0] INMODE_A2B2 = 5'b00000;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2,
    ST_HOLD  = 2'd3
  } mac_state_e;

  // One slot travelling alongside the slice pipeline
  typedef struct packed {
    logic valid;
    logic last;
  } mac_tag_t;

  // Sign-extend a 25-bit multiplicand onto the 30-bit A port
  function automatic logic [29:0] sext_a(input logic [24:0] a);
    return {{5{a[24]}}, a};
  endfunction

endpackage

// File: rtl/mac_tag_pipe.sv
// DEPTH-deep shift register of {valid, last} tags mirroring the slice
// pipeline. Stage 0 holds the slot whose operands sit on dsp_a/dsp_b;
// stage k holds the slot k cycles further in. Synchronous clear flushes all.
module mac_tag_pipe
  import dsp48e1_pkg::*;
#(
  parameter int DEPTH = 3
) (
  input  logic             clk_i,
  input  logic             clr_i,
  input  mac_tag_t         tag_i,
  output logic [DEPTH-1:0] valid_o,
  output logic [DEPTH-1:0] last_o
);

  mac_tag_t stage_q [DEPTH];

  // Shift one stage per clock; a bubble travels as an invalid tag
  always_ff @(posedge clk_i) begin
    if (clr_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) begin
        stage_q[i] <= stage_q[i-1];
      end
    end
  end

  // Flatten per-stage fields for the consumer
  always_comb begin
    valid_o = '0;
    last_o  = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_o[i] = stage_q[i].valid;
      last_o[i]  = stage_q[i].last;
    end
  end

endmodule

// File: rtl/dsp48e1_mac_sequencer.sv
// Dot-product sequencer for one DSP48E1 slice (AREG/BREG=1, MREG=1, PREG=1
// at the default DSP_LAT=3). Streams operand pairs into the slice, steers
// OPMODE between P=A*B and P+=A*B, gates every clock enable with a tag that
// rides alongside the data, and captures the final P into a held result.
// Optional build macro MAC_SEQ_OVF_EN adds dsp_overflow/dsp_underflow inputs
// and a sticky res_ovf output presented with the result.
//
// Handshakes: a transfer happens on a rising CLK edge where both valid and
// ready are high. Ready never depends combinationally on valid; a producer
// holds valid and its payload stable until the transfer edge. This applies
// to cmd_valid/cmd_ready, in_valid/in_ready and res_valid/res_ready.
module dsp48e1_mac_sequencer
  import dsp48e1_pkg::*;
#(
  parameter int DSP_LAT = 3,  // 1..4: registered dsp_a/dsp_b to P update
  parameter int OPM_DLY = 1,  // 0..DSP_LAT-1: OPMODE lag behind dsp_a/dsp_b
  parameter int LEN_W   = 10
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             cmd_valid,
  input  logic [LEN_W-1:0] cmd_len,
  output logic             cmd_ready,
  input  logic             in_valid,
  input  logic [24:0]      in_a,
  input  logic [17:0]      in_b,
  output logic             in_ready,
  output logic [29:0]      dsp_a,
  output logic [17:0]      dsp_b,
  output logic [6:0]       dsp_opmode,
  output logic [3:0]       dsp_alumode,
  output logic [2:0]       dsp_carryinsel,
  output logic [4:0]       dsp_inmode,
  output logic             dsp_cea2,
  output logic             dsp_ceb2,
  output logic             dsp_cem,
  output logic             dsp_cep,
  output logic             dsp_cectrl,
  output logic             dsp_rstp,
  input  logic [47:0]      dsp_p,
  output logic [47:0]      res_data,
  output logic             res_valid,
  input  logic             res_ready,
`ifdef MAC_SEQ_OVF_EN
  input  logic             dsp_overflow,
  input  logic             dsp_underflow,
  output logic             res_ovf,
`endif
  output mac_state_e       dbg_state_o
);

  // Stage whose tag enables the M register; collapses to 0 for short pipes
  localparam int CEM_STAGE = (DSP_LAT < 2) ? 0 : DSP_LAT - 2;

  mac_state_e       state_q;
  logic [LEN_W-1:0] len_q;
  logic [LEN_W-1:0] cnt_q;
  logic             cmd_ready_q;
  logic             in_ready_q;
  logic             res_valid_q;
  logic [47:0]      res_data_q;
  logic [29:0]      dsp_a_q;
  logic [17:0]      dsp_b_q;
  logic [6:0]       opm0_q;
  logic             exit_q;

  logic               accept;
  logic               is_last;
  mac_tag_t           tag_in;
  logic [DSP_LAT-1:0] tag_valid;
  logic [DSP_LAT-1:0] tag_last;

  assign accept  = in_valid & in_ready_q;
  assign is_last = (cnt_q == len_q - LEN_W'(1));
  assign tag_in  = {accept, accept & is_last};

  mac_tag_pipe #(
    .DEPTH (DSP_LAT)
  ) u_tag_pipe (
    .clk_i   (CLK),
    .clr_i   (RST),
    .tag_i   (tag_in),
    .valid_o (tag_valid),
    .last_o  (tag_last)
  );

  // Sequencer FSM with all registered outputs and operand capture
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      len_q       <= '0;
      cnt_q       <= '0;
      cmd_ready_q <= 1'b1;
      in_ready_q  <= 1'b0;
      res_valid_q <= 1'b0;
      res_data_q  <= '0;
      dsp_a_q     <= '0;
      dsp_b_q     <= '0;
      opm0_q      <= '0;
      exit_q      <= 1'b0;
    end else begin
      // The last tag left the final stage: P holds the finished sum now
      exit_q <= tag_valid[DSP_LAT-1] & tag_last[DSP_LAT-1];
      case (state_q)
        ST_IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            len_q       <= cmd_len;
            cnt_q       <= '0;
            cmd_ready_q <= 1'b0;
            if (cmd_len != '0) begin
              state_q    <= ST_RUN;
              in_ready_q <= 1'b1;
            end else begin
              state_q     <= ST_HOLD;
              res_data_q  <= '0;
              res_valid_q <= 1'b1;
            end
          end
        end
        ST_RUN: begin
          if (accept) begin
            dsp_a_q <= sext_a(in_a);
            dsp_b_q <= in_b;
            opm0_q  <= (cnt_q == '0) ? OPM_MUL : OPM_MAC;
            cnt_q   <= cnt_q + LEN_W'(1);
            if (is_last) begin
              state_q    <= ST_DRAIN;
              in_ready_q <= 1'b0;
            end
          end
        end
        ST_DRAIN: begin
          if (exit_q) begin
            res_data_q  <= dsp_p;
            res_valid_q <= 1'b1;
            state_q     <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state_q     <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // OPMODE lags the operands so it lines up with the M stage
  generate
    if (OPM_DLY == 0) begin : g_opm_nodly
      assign dsp_opmode = opm0_q;
    end else begin : g_opm_dly
      logic [6:0] opm_pipe_q [OPM_DLY];
      // Delay line for the per-term opcode
      always_ff @(posedge CLK) begin
        if (RST) begin
          for (int i = 0; i < OPM_DLY; i++) begin
            opm_pipe_q[i] <= '0;
          end
        end else begin
          opm_pipe_q[0] <= opm0_q;
          for (int i = 1; i < OPM_DLY; i++) begin
            opm_pipe_q[i] <= opm_pipe_q[i-1];
          end
        end
      end
      assign dsp_opmode = opm_pipe_q[OPM_DLY-1];
    end
  endgenerate

`ifdef MAC_SEQ_OVF_EN
  logic ovf_q;

  // Sticky flag over every P update of the current job
  always_ff @(posedge CLK) begin
    if (RST) begin
      ovf_q <= 1'b0;
    end else if (state_q == ST_IDLE && cmd_valid && cmd_ready_q) begin
      ovf_q <= 1'b0;
    end else if (dsp_cep && (dsp_overflow || dsp_underflow)) begin
      ovf_q <= 1'b1;
    end
  end

  assign res_ovf = ovf_q & res_valid_q;
`endif

  // Clock enables follow the tag of the slot occupying each slice stage
  assign dsp_cea2   = tag_valid[0];
  assign dsp_ceb2   = tag_valid[0];
  assign dsp_cem    = tag_valid[CEM_STAGE];
  assign dsp_cep    = tag_valid[DSP_LAT-1];
  assign dsp_cectrl = tag_valid[OPM_DLY];
  assign dsp_rstp   = RST;

  assign dsp_alumode    = ALUMODE_ADD;
  assign dsp_carryinsel = CARRYINSEL_PIN;
  assign dsp_inmode     = INMODE_A2B2;

  assign dsp_a       = dsp_a_q;
  assign dsp_b       = dsp_b_q;
  assign cmd_ready   = cmd_ready_q & ~RST;
  assign in_ready    = in_ready_q;
  assign res_valid   = res_valid_q;
  assign res_data    = res_data_q;
  assign dbg_state_o = state_q;

  // Not every stage field is consumed for every parameter choice
  logic unused_tag_bits;
  assign unused_tag_bits = ^{tag_valid, tag_last};

endmodule

// File: tb/tb_dsp48e1_mac_sequencer.sv
// Bench for dsp48e1_mac_sequencer with a behavioural DSP48E1 slice model
// (A2/B2, M, OPMODE and P registers) closing the loop on dsp_p.
module tb_dsp48e1_mac_sequencer;
  import dsp48e1_pkg::*;

  localparam int DSP_LAT = 3;
  localparam int LEN_W   = 10;
  // Negedge after the edge that raises res_valid, measured from a handshake edge
  localparam time LAT_T  = (DSP_LAT + 1) * 10 + 5;

  // ---------------- clock / reset ----------------
  logic CLK = 1'b0;
  logic RST = 1'b1;
  always #5 CLK = ~CLK;

  logic             cmd_valid = 1'b0;
  logic [LEN_W-1:0] cmd_len   = '0;
  logic             cmd_ready;
  logic             in_valid  = 1'b0;
  logic [24:0]      in_a      = '0;
  logic [17:0]      in_b      = '0;
  logic             in_ready;
  logic [29:0]      dsp_a;
  logic [17:0]      dsp_b;
  logic [6:0]       dsp_opmode;
  logic [3:0]       dsp_alumode;
  logic [2:0]       dsp_carryinsel;
  logic [4:0]       dsp_inmode;
  logic             dsp_cea2, dsp_ceb2, dsp_cem, dsp_cep, dsp_cectrl, dsp_rstp;
  logic [47:0]      dsp_p;
  logic [47:0]      res_data;
  logic             res_valid;
  logic             res_ready = 1'b0;
  mac_state_e       dbg_state;

  dsp48e1_mac_sequencer #(
    .DSP_LAT (DSP_LAT),
    .OPM_DLY (1),
    .LEN_W   (LEN_W)
  ) dut (
    .CLK            (CLK),
    .RST            (RST),
    .cmd_valid      (cmd_valid),
    .cmd_len        (cmd_len),
    .cmd_ready      (cmd_ready),
    .in_valid       (in_valid),
    .in_a           (in_a),
    .in_b           (in_b),
    .in_ready       (in_ready),
    .dsp_a          (dsp_a),
    .dsp_b          (dsp_b),
    .dsp_opmode     (dsp_opmode),
    .dsp_alumode    (dsp_alumode),
    .dsp_carryinsel (dsp_carryinsel),
    .dsp_inmode     (dsp_inmode),
    .dsp_cea2       (dsp_cea2),
    .dsp_ceb2       (dsp_ceb2),
    .dsp_cem        (dsp_cem),
    .dsp_cep        (dsp_cep),
    .dsp_cectrl     (dsp_cectrl),
    .dsp_rstp       (dsp_rstp),
    .dsp_p          (dsp_p),
    .res_data       (res_data),
    .res_valid      (res_valid),
    .res_ready      (res_ready),
    .dbg_state_o    (dbg_state)
  );

  // ---------------- behavioural slice ----------------
  logic [29:0]        a2_m;
  logic signed [17:0] b2_m;
  logic signed [42:0] m_m;
  logic [6:0]         opm_m;
  logic [47:0]        p_m;

  always_ff @(posedge CLK) begin
    if (dsp_rstp) begin
      a2_m  <= '0;
      b2_m  <= '0;
      m_m   <= '0;
      opm_m <= '0;
      p_m   <= '0;
    end else begin
      if (dsp_cea2)   a2_m  <= dsp_a;
      if (dsp_ceb2)   b2_m  <= dsp_b;
      if (dsp_cem)    m_m   <= $signed(a2_m[24:0]) * b2_m;
      if (dsp_cectrl) opm_m <= dsp_opmode;
      if (dsp_cep)    p_m   <= ((opm_m[6:4] == 3'b010) ? p_m : 48'd0) + {{5{m_m[42]}}, m_m};
    end
  end
  assign dsp_p = p_m;

  // ---------------- scoreboard state ----------------
  int          checks = 0;
  int          errors = 0;
  logic [47:0] exp_q[$];
  logic [6:0]  opm_log[$];
  int          cep_cnt = 0;
  bit          in_ready_seen = 1'b0;
  time         hs_t = 0;
  time         cmd_t = 0;

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Monitor: pops an expected result on every result handshake
  task automatic monitor_loop();
    forever begin
      @(negedge CLK);
      if (dsp_cep) cep_cnt++;
      if (dsp_cectrl) opm_log.push_back(dsp_opmode);
      if (in_ready) in_ready_seen = 1'b1;
      if (!RST && res_valid && res_ready) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_result: got %0h with empty queue", res_data);
        end else begin
          check("result_data", res_data, exp_q.pop_front());
        end
      end
    end
  endtask

  // ---------------- driver tasks (called just after a posedge) ----------------
  task automatic send_cmd(input logic [LEN_W-1:0] len);
    bit ok = 1'b0;
    int w = 0;
    cmd_valid = 1'b1;
    cmd_len   = len;
    while (!ok && w < 100) begin
      @(negedge CLK);
      ok = cmd_ready;
      @(posedge CLK);
      #1;
      w++;
    end
    if (ok) cmd_t = $time - 1;
    else begin
      checks++; errors++;
      $display("FAIL cmd_timeout: cmd_ready low for %0d cycles", w);
    end
    cmd_valid = 1'b0;
  endtask

  task automatic send_term(input logic signed [24:0] a, input logic signed [17:0] b);
    bit ok = 1'b0;
    int w = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    while (!ok && w < 100) begin
      @(negedge CLK);
      ok = in_ready;
      @(posedge CLK);
      #1;
      w++;
    end
    if (ok) hs_t = $time - 1;
    else begin
      checks++; errors++;
      $display("FAIL in_timeout: in_ready low for %0d cycles", w);
    end
  endtask

  task automatic idle(input int n);
    in_valid = 1'b0;
    repeat (n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Returns (at a negedge) the time res_valid was first seen high
  task automatic wait_result(output time t);
    int w = 0;
    t = 0;
    @(negedge CLK);
    while (!res_valid && w < 200) begin
      @(negedge CLK);
      w++;
    end
    if (res_valid) t = $time;
    else begin
      checks++; errors++;
      $display("FAIL result_timeout: no res_valid within %0d cycles", w);
    end
  endtask

  task automatic release_result();
    @(posedge CLK);
    #1 res_ready = 1'b1;
    @(posedge CLK);
    #1 res_ready = 1'b0;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    time t;
    int  cep0;
    int  o0;
    fork
      monitor_loop();
    join_none

    // Reset values
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_res_valid", res_valid, 0);
    check("rst_res_data", res_data, 0);
    check("rst_dsp_a", dsp_a, 0);
    check("rst_dsp_b", dsp_b, 0);
    check("rst_opmode", dsp_opmode, 0);
    check("rst_ces", {dsp_cea2, dsp_ceb2, dsp_cem, dsp_cep, dsp_cectrl}, 0);
    check("rst_rstp", dsp_rstp, 1);
    @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_rstp", dsp_rstp, 0);
    check("post_rst_state", dbg_state, ST_IDLE);
    check("const_ctrl", {dsp_alumode, dsp_carryinsel, dsp_inmode}, 0);
    @(posedge CLK);
    #1;

    // Base accumulation: 1*2+2*2+3*2+4*2 = 20, back-to-back
    cep0 = cep_cnt;
    exp_q.push_back(48'd20);
    send_cmd(4);
    send_term(1, 2);
    send_term(2, 2);
    send_term(3, 2);
    send_term(4, 2);
    in_valid = 1'b0;
    wait_result(t);
    check("base_last_to_valid", t - hs_t, LAT_T);
    check("base_cmd_to_valid", t - cmd_t, 85);
    release_result();
    check("base_cep_pulses", cep_cnt - cep0, 4);

    // Bubbles between terms 2 and 3
    cep0 = cep_cnt;
    exp_q.push_back(48'd20);
    send_cmd(4);
    send_term(1, 2);
    send_term(2, 2);
    idle(2);
    send_term(3, 2);
    send_term(4, 2);
    in_valid = 1'b0;
    wait_result(t);
    check("bubble_last_to_valid", t - hs_t, LAT_T);
    release_result();
    check("bubble_cep_pulses", cep_cnt - cep0, 4);

    // Signed operands: (-3*5)+(7*-2) = -29
    o0 = opm_log.size();
    exp_q.push_back(48'hFFFF_FFFF_FFE3);
    send_cmd(2);
    send_term(-3, 5);
    check("sext_dsp_a", dsp_a, 30'h3FFF_FFFD);
    check("dsp_b_pass", dsp_b, 18'h00005);
    send_term(7, -2);
    in_valid = 1'b0;
    wait_result(t);
    release_result();
    check("signed_cectrl_count", opm_log.size() - o0, 2);
    check("signed_opmode_first", (opm_log.size() > o0) ? opm_log[o0] : 7'h7F, 7'h05);
    check("signed_opmode_second", (opm_log.size() > o0 + 1) ? opm_log[o0+1] : 7'h7F, 7'h25);

    // Zero length: result the cycle after the command, no operand accepted
    in_ready_seen = 1'b0;
    exp_q.push_back(48'd0);
    send_cmd(0);
    wait_result(t);
    check("zero_cmd_to_valid", t - cmd_t, 5);
    release_result();
    check("zero_in_ready_never", in_ready_seen, 0);

    // Back-pressure: (100*-1)+(200*3)+(-50*4) = 300, result held 10 cycles
    exp_q.push_back(48'd300);
    send_cmd(3);
    send_term(100, -1);
    send_term(200, 3);
    send_term(-50, 4);
    in_valid = 1'b0;
    wait_result(t);
    @(posedge CLK);
    #1;
    cmd_valid = 1'b1;
    cmd_len   = 1;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      check("bp_res_data", res_data, 48'd300);
      check("bp_cmd_ready", cmd_ready, 0);
      check("bp_res_valid", res_valid, 1);
      @(posedge CLK);
      #1;
    end
    exp_q.push_back(48'd25);
    res_ready = 1'b1;
    @(negedge CLK);
    check("bp_cmd_ready_at_hs", cmd_ready, 0);
    @(posedge CLK);
    #1 res_ready = 1'b0;
    @(negedge CLK);
    check("bp_idle_after_hs", dbg_state, ST_IDLE);
    @(posedge CLK);
    #1 cmd_valid = 1'b0;
    check("bp_cmd_taken", dbg_state, ST_RUN);
    send_term(5, 5);
    in_valid = 1'b0;
    wait_result(t);
    release_result();

    // Reset mid-job after term 2 of 5, then 6*7 = 42
    send_cmd(5);
    send_term(1, 1);
    send_term(2, 2);
    in_valid = 1'b0;
    RST = 1'b1;
    @(posedge CLK);
    #1;
    @(negedge CLK);
    check("midrst_cmd_ready", cmd_ready, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_res_valid", res_valid, 0);
    check("midrst_dsp_a", dsp_a, 0);
    check("midrst_opmode", dsp_opmode, 0);
    check("midrst_ces", {dsp_cea2, dsp_ceb2, dsp_cem, dsp_cep, dsp_cectrl}, 0);
    check("midrst_rstp", dsp_rstp, 1);
    check("midrst_state", dbg_state, ST_IDLE);
    @(posedge CLK);
    #1 RST = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge CLK);
      check("midrst_no_partial", res_valid, 0);
    end
    @(posedge CLK);
    #1;
    exp_q.push_back(48'd42);
    send_cmd(1);
    send_term(6, 7);
    in_valid = 1'b0;
    wait_result(t);
    check("after_rst_last_to_valid", t - hs_t, LAT_T);
    release_result();

    repeat (5) @(posedge CLK);
    check("scoreboard_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Absolute backstop in case a wait escapes its bound
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
